lut_table_writer: RTL
=====================

# lut_table_writer

Runtime-programmable LUT neuron for the quantized HGCAL autoencoder. Fixed-ROM neurons hold their truth tables in synthesized logic. This block is the writer side of that table: it accepts a streamed truth table over a valid/ready handshake and stores it in a distributed RAM. It then serves inference lookups with the same M0-in / M1-out contract, so a layer can be re-programmed without re-synthesis.

## Interface
Parameters:
- IN_BITS, 8, lookup address width (fan-in × input bit-width); table depth is 2**IN_BITS
- OUT_BITS, 2, output activation width per table entry

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_start  input  1  pulse: begin loading a new table
- cfg_data  input  OUT_BITS  table entry for the current write address
- cfg_valid  input  1  cfg_data valid
- cfg_ready  output  1  writer accepts cfg_data this cycle
- cfg_busy  output  1  load in progress
- cfg_done  output  1  one-cycle pulse after the last entry is written
- table_valid  output  1  a complete table is resident
- M0  input  IN_BITS  lookup address
- in_valid  input  1  M0 valid
- M1  output  OUT_BITS  registered lookup result
- out_valid  output  1  M1 valid

## Operation
- Storage: ENTRIES = 2**IN_BITS words of OUT_BITS, distributed RAM style.
  - Contents are not reset.
  - One write port, one asynchronous read port followed by the output register.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: cfg_ready=0. cfg_start=1 → LOAD, write address ← 0, table_valid ← 0.
  - LOAD: cfg_ready=1, cfg_busy=1. Each beat with cfg_valid&cfg_ready writes cfg_data to table[addr] and increments addr.
    - The beat at addr = ENTRIES-1 → DONE.
    - cfg_start in LOAD is ignored; it does not restart the load.
    - cfg_valid low stalls with no write and addr held.
  - DONE: single cycle. cfg_done=1, table_valid ← 1, cfg_ready=0, cfg_busy=0 → IDLE.
- Entry order: natural binary address; entry k is the output for M0 = k.
- Address counter is IN_BITS+0 wide. The final increment wraps to 0 and is never used as a write address.
- Lookup runs every cycle, independent of the FSM:
  - out_valid ← in_valid.
  - M1 ← table[M0] when table_valid=1, else M1 ← 0.
- Re-programming: cfg_start in IDLE with table_valid=1 starts a new load.
  - table_valid drops the cycle after cfg_start.
  - Lookups return 0 until the new DONE.
- cfg_data/cfg_valid arriving in IDLE or DONE are dropped (cfg_ready=0).

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, addr=0, cfg_ready=0, cfg_busy=0, cfg_done=0, table_valid=0, M1=0, out_valid=0.
- cfg_start sampled at edge t → cfg_ready=1 from t+1.
- A full load with continuous cfg_valid takes ENTRIES beats:
  - last beat accepted at edge t+ENTRIES;
  - cfg_done=1 and table_valid=1 during cycle t+ENTRIES+1;
  - IDLE at t+ENTRIES+2.
- Lookup latency is 1 cycle: M0/in_valid sampled at edge t gives M1/out_valid during t+1. Throughput is 1 lookup/cycle.
- A lookup sampled in the same edge that writes the last entry sees table_valid=0 and returns 0. The first valid lookup is sampled during DONE.
- Reset mid-load: FSM returns to IDLE and table_valid=0. Partially written contents stay but are never exposed.
- cfg_valid may be held high across the LOAD→DONE boundary; the extra beat is not accepted.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately. Lookup of M0=8'hFF after release → M1=0, out_valid follows in_valid with 1-cycle delay.
- Full load, continuous stream: cfg_data = k[1:0] for entry k, then sweep M0=0..255 → M1 = M0[1:0] each cycle, 1-cycle latency. cfg_done pulses exactly once, 257 cycles after the cfg_start edge.
- Stalled load: random cfg_valid gaps over a 256-entry pattern of all 2'b11 except entry 8'h5A=2'b01. Lookup 8'h5A → 2'b01, 8'h5B → 2'b11. No write on gap cycles.
- Reload: after a table of all 2'b10, cfg_start with lookups running.
  - Lookups return 0 from the cycle after cfg_start until DONE.
  - After loading all 2'b01, every lookup returns 2'b01.
  - cfg_start issued during LOAD causes no restart; addr is unaffected.
- Reset mid-load at entry 100 → table_valid=0 and state IDLE. A new cfg_start and full load then behave normally.
- Extra beat: keep cfg_valid=1 with data 2'b11 one cycle past entry 255 (loaded value 2'b00) → entry 0 still reads 2'b00 and cfg_ready=0 in DONE.

Source files
------------

// File: rtl/lut_table_writer_if.sv
// Handshake bundle for the LUT table writer: streamed table load on the cfg_* side,
// single-cycle lookups on the M0/M1 side.
interface lut_table_writer_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
);
  logic                cfg_start;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_busy;
  logic                cfg_done;
  logic                table_valid;
  logic [IN_BITS-1:0]  M0;
  logic                in_valid;
  logic [OUT_BITS-1:0] M1;
  logic                out_valid;

  modport master (
    output cfg_start, cfg_data, cfg_valid, M0, in_valid,
    input  cfg_ready, cfg_busy, cfg_done, table_valid, M1, out_valid
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid, M0, in_valid,
    output cfg_ready, cfg_busy, cfg_done, table_valid, M1, out_valid
  );
endinterface

// File: rtl/lut_table_writer.sv
// Runtime-programmable LUT neuron: loads a streamed truth table into distributed RAM
// and serves registered lookups from it once a complete table is resident.
module lut_table_writer #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  lut_table_writer_if.slave bus
);
  localparam int ENTRIES = 2 ** IN_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  addr_q, addr_d;
  logic                table_valid_q, table_valid_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;
  logic                out_valid_q, out_valid_d;
  logic                wr_en;

  logic [OUT_BITS-1:0] mem [ENTRIES];

  // The all-ones address is the last entry; its beat closes the load.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    table_valid_d = table_valid_q;
    wr_en         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d       = LOAD;
          addr_d        = '0;
          table_valid_d = 1'b0;
        end
      end
      LOAD: begin
        if (bus.cfg_valid) begin
          wr_en  = 1'b1;
          addr_d = addr_q + IN_BITS'(1);
          if (&addr_q) begin
            state_d       = DONE;
            table_valid_d = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    m1_d        = table_valid_q ? mem[bus.M0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      table_valid_q <= 1'b0;
      m1_q          <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      table_valid_q <= table_valid_d;
      m1_q          <= m1_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Table contents are deliberately not reset; table_valid gates their visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_q] <= bus.cfg_data;
    end
  end

  assign bus.cfg_ready   = (state_q == LOAD);
  assign bus.cfg_busy    = (state_q == LOAD);
  assign bus.cfg_done    = (state_q == DONE);
  assign bus.table_valid = table_valid_q;
  assign bus.M1          = m1_q;
  assign bus.out_valid   = out_valid_q;

endmodule
